win_reg_img: RTL
================

# win_reg_img

Bidirectional sliding-window register for the convolution datapath. It accepts one K_H-pixel image column per handshake and holds the most recent K_W columns as a full K_H×K_W window. It presents that window to the PE array with a valid/ready handshake and tracks fill level. The shift direction is selectable per column, so serpentine (left-to-right, then right-to-left) scans reuse the resident columns at row turnarounds.

## Interface
- DW, 8, pixel width in bits
- K_H, 3, window rows (pixels per input column), ≥1
- K_W, 3, window columns, ≥2
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- clear  in  1  synchronous flush of window, fill count and fresh flag
- dir  in  1  shift direction for the accepted column: 0 = new column enters col 0 and data moves toward col K_W-1; 1 = new column enters col K_W-1 and data moves toward col 0
- in_valid  in  1  in_data carries a column
- in_ready  out  1  block can accept a column this cycle
- in_data  in  K_H×DW  column pixels, index = row
- in_pad  in  1  load the accepted column as zeros (present only with WIN_REG_ZERO_PAD_EN)
- out_valid  out  1  fresh full window available
- out_ready  in  1  consumer takes the window this cycle
- out_win  out  K_H×K_W×DW  window registers, [row][col]
- fill  out  $clog2(K_W+1)  number of valid columns resident, 0..K_W

## Operation
- State: win[K_H][K_W], fill counter, fresh flag. out_valid = fresh, and fresh implies fill==K_W.
- in_ready = (fill<K_W) | ~fresh | out_ready. A full, unconsumed window is never overwritten.
- Accept (in_valid & in_ready), dir=0: win[r][c] <= win[r][c-1] for c≥1, and win[r][0] <= in_data[r] for every row r including row 0.
- Accept, dir=1: win[r][c] <= win[r][c+1] for c≤K_W-2, and win[r][K_W-1] <= in_data[r].
- Accept: fill <= min(fill+1, K_W). fresh <= 1 if the new fill == K_W.
- out_ready & out_valid without an accept in the same cycle: fresh <= 0. The window contents and fill are unchanged.
- Consume and accept in the same cycle: the shift happens and fresh stays 1, giving a back-to-back window every cycle.
- A direction change does not alter fill. After a turnaround, the next window is valid as soon as one column is accepted, provided fill == K_W.
- clear: all win <= 0, fill <= 0, fresh <= 0. clear has priority over accept and consume in the same cycle, and in_data is discarded.
- While fill < K_W, accepted columns raise fill and out_valid stays 0.

## Timing
- Reset (async) and clear (sync) values: win = 0, fill = 0, out_valid = 0, and in_ready = 1 one combinational evaluation later.
- Latency: out_win reflects the accepted column on the cycle after the accept edge. out_valid rises on the edge of the K_W-th accept after reset or clear.
- in_ready and out_valid are functions of registers plus out_ready only. There is no in_valid→in_ready path.
- Sustained throughput is 1 column/cycle once full, as long as out_ready=1.
- Reset asserted mid-fill or mid-stall discards everything, and the next window again needs K_W accepts.

## Configuration
- WIN_REG_ZERO_PAD_EN defined: the in_pad port exists. An accepted column with in_pad=1 loads 0 in all rows and otherwise counts toward fill exactly like a data column. This is used for left/right image borders.
- Not defined: no in_pad port, and in_data is always loaded.

## Structure
- Shared package npu_win_pkg holds:
  - default DW, K_H, K_W localparams
  - typedef pix_t (logic [DW-1:0])
  - the direction encoding constants DIR_FWD = 0 and DIR_REV = 1
- One sub-module, win_reg_row: one K_W-deep bidirectional shift row with load, dir and clear. It is instantiated K_H times.
- Fill, fresh and handshake logic stay in the top.

## Test plan
- Reset, then accept columns of 1s, 2s and 3s with dir=0 and out_ready=0:
  - out_valid rises after the 3rd accept.
  - out_win row r = {3,2,1} (col 0..2).
  - fill = 3 and in_ready = 0.
- From that full state, hold in_valid=1 and raise out_ready:
  - accepted columns 4 and 5 on consecutive cycles each give out_valid=1.
  - the final row = {5,4,3}.
- From {5,4,3}, accept column 9 with dir=1: the row becomes {4,3,9}, fill stays 3, and out_valid=1 the next cycle.
- Assert clear on the same cycle as an accept of column 7:
  - win is all 0, fill = 0, out_valid = 0.
  - column 7 is not loaded.
- Assert rst_n low mid-fill (fill = 2) asynchronously: outputs are 0 immediately, and three further accepts are needed for out_valid.
- With WIN_REG_ZERO_PAD_EN, accept pad, then 6, then 8 with dir=0: the row = {8,6,0} and out_valid=1.

Source files
------------

// File: rtl/npu_win_pkg.sv
// Shared types and defaults for the convolution sliding-window registers.
// Pure declarations: no logic, no latency, no flow control.
package npu_win_pkg;
    localparam int DEF_DW  = 8;
    localparam int DEF_K_H = 3;
    localparam int DEF_K_W = 3;

    typedef logic [DEF_DW-1:0] pix_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;
endpackage

// File: rtl/win_reg_img_if.sv
// Column-in / window-out bus of win_reg_img; in_pad exists only with WIN_REG_ZERO_PAD_EN.
// master = column producer and window consumer, slave = the window register.
interface win_reg_img_if
    import npu_win_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int K_H = DEF_K_H,
    parameter int K_W = DEF_K_W
);
    localparam int FW = $clog2(K_W + 1);

    logic                               clear;
    logic                               dir;
    logic                               in_valid;
    logic                               in_ready;
    logic [K_H-1:0][DW-1:0]             in_data;
`ifdef WIN_REG_ZERO_PAD_EN
    logic                               in_pad;
`endif
    logic                               out_valid;
    logic                               out_ready;
    logic [K_H-1:0][K_W-1:0][DW-1:0]    out_win;
    logic [FW-1:0]                      fill;

    modport master (
`ifdef WIN_REG_ZERO_PAD_EN
        output in_pad,
`endif
        output clear, dir, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_win, fill
    );

    modport slave (
`ifdef WIN_REG_ZERO_PAD_EN
        input  in_pad,
`endif
        input  clear, dir, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_win, fill
    );
endinterface

// File: rtl/win_reg_row.sv
// One K_W-deep bidirectional shift row of the window; clear wins over load.
// Latency: loaded pixel visible on taps the cycle after the load edge; no backpressure.
module win_reg_row
    import npu_win_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int K_W = DEF_K_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    dir,
    input  logic [DW-1:0]           din,
    output logic [K_W-1:0][DW-1:0]  taps
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps <= '0;
        end else if (clear) begin
            taps <= '0;
        end else if (load) begin
            if (dir == DIR_FWD) begin
                taps[0] <= din;
                for (int c = 1; c < K_W; c++) taps[c] <= taps[c-1];
            end else begin
                taps[K_W-1] <= din;
                for (int c = 0; c < K_W - 1; c++) taps[c] <= taps[c+1];
            end
        end
    end
endmodule

// File: rtl/win_reg_img.sv
// Sliding K_HxK_W window register with per-column shift direction (pad port: WIN_REG_ZERO_PAD_EN).
// Latency: window updates one cycle after accept; out_valid rises on the K_W-th accept.
// Backpressure: in_ready drops only when the window is full, fresh and out_ready is low.
module win_reg_img
    import npu_win_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int K_H = DEF_K_H,
    parameter int K_W = DEF_K_W
) (
    input  logic          clk,
    input  logic          rst_n,
    win_reg_img_if.slave  bus
);
    localparam int             FW   = $clog2(K_W + 1);
    localparam logic [FW-1:0]  FULL = FW'(K_W);

    logic [FW-1:0]                    fill_q;
    logic [FW-1:0]                    fill_nxt;
    logic                             fresh_q;
    logic                             accept;
    logic [K_H-1:0][DW-1:0]           row_din;
    logic [K_H-1:0][K_W-1:0][DW-1:0]  win;

    // No in_valid term here, so in_ready never depends combinationally on in_valid.
    assign bus.in_ready  = (fill_q != FULL) | ~fresh_q | bus.out_ready;
    assign accept        = bus.in_valid & bus.in_ready;
    assign fill_nxt      = (fill_q == FULL) ? FULL : fill_q + 1'b1;
    assign bus.out_valid = fresh_q;
    assign bus.fill      = fill_q;
    assign bus.out_win   = win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q  <= '0;
            fresh_q <= 1'b0;
        end else if (bus.clear) begin
            fill_q  <= '0;
            fresh_q <= 1'b0;
        end else if (accept) begin
            fill_q  <= fill_nxt;
            fresh_q <= (fill_nxt == FULL);
        end else if (bus.out_ready & fresh_q) begin
            fresh_q <= 1'b0;
        end
    end

    for (genvar r = 0; r < K_H; r++) begin : g_row
`ifdef WIN_REG_ZERO_PAD_EN
        assign row_din[r] = bus.in_pad ? '0 : bus.in_data[r];
`else
        assign row_din[r] = bus.in_data[r];
`endif
        win_reg_row #(
            .DW  (DW),
            .K_W (K_W)
        ) u_row (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (bus.clear),
            .load  (accept),
            .dir   (bus.dir),
            .din   (row_din[r]),
            .taps  (win[r])
        );
    end
endmodule
